// File: rtl/out_bus_scheduler_pkg.sv
// rtl/out_bus_scheduler_pkg.sv - shared constants for the output bus scheduler
//
// Purpose: FSM state encodings, default core count and burst lengths, and the
// per-core phase encoding (which burst type a core gets next).
// Ports: none (package).
package out_bus_scheduler_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int OUT_ARB_NUM_CORES    = 4;
    localparam int DEFAULT_ADD_BURST    = 16;
    localparam int DEFAULT_UNLOAD_BURST = 16;

    // A core alternates add (partial sums in) and unload (results out) bursts.
    localparam logic PHASE_ADD    = 1'b0;
    localparam logic PHASE_UNLOAD = 1'b1;

endpackage

// File: rtl/out_bus_scheduler_rr_priority_picker.sv
// rtl/out_bus_scheduler_rr_priority_picker.sv - rotating priority encoder
//
// Purpose: picks the first asserted request searching upward from ptr+1,
// wrapping modulo N, so the core at ptr has lowest priority.
// Ports:
//   req  in   N      request vector
//   ptr  in   IDX_W  index of the most recently served core (must be < N)
//   gnt  out  N      one-hot winner, 0 when no request
//   idx  out  IDX_W  index of the winner
//   any  out  1      at least one request present
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/out_bus_scheduler.sv
// rtl/out_bus_scheduler.sv - round-robin output bus scheduler with add/unload bursts
//
// Purpose: arbitrates the shared output bus among PE cores, alternating each
// core between add and unload bursts, and sequences beats against w_bus_ack.
// Ports:
//   w_clock     in   1          clock, rising edge
//   w_ready     in   1          asynchronous active-low reset
//   w_req       in   NUM_CORES  level request per core
//   w_bus_ack   in   1          buffer accepts the current beat
//   grant       out  NUM_CORES  one-hot bus owner, 0 when idle
//   burst       out  BURST_W    current burst length, 0 when idle
//   add_en      out  1          current burst is an add burst
//   unload_en   out  1          current burst is an unload burst
//   rw          out  1          0 = add (write into buffer), 1 = unload
//   addr        out  BURST_W    beat index within burst
//   beat_valid  out  1          beat presented this cycle
//   done        out  1          one-cycle pulse after last beat accepted
module out_bus_scheduler
    import out_bus_scheduler_pkg::*;
#(
    parameter int NUM_CORES    = OUT_ARB_NUM_CORES,
    parameter int BURST_W      = 6,
    parameter int ADD_BURST    = DEFAULT_ADD_BURST,
    parameter int UNLOAD_BURST = DEFAULT_UNLOAD_BURST
) (
    input  logic                 w_clock,
    input  logic                 w_ready,
    input  logic [NUM_CORES-1:0] w_req,
    input  logic                 w_bus_ack,
    output logic [NUM_CORES-1:0] grant,
    output logic [BURST_W-1:0]   burst,
    output logic                 add_en,
    output logic                 unload_en,
    output logic                 rw,
    output logic [BURST_W-1:0]   addr,
    output logic                 beat_valid,
    output logic                 done
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    logic [1:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     own_idx;
    logic [NUM_CORES-1:0] phase;

    logic [NUM_CORES-1:0] pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_priority_picker #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (w_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge w_clock or negedge w_ready) begin
        if (!w_ready) begin
            state      <= ST_IDLE;
            ptr        <= IDX_W'(NUM_CORES - 1);
            own_idx    <= '0;
            phase      <= '0;
            grant      <= '0;
            burst      <= '0;
            add_en     <= 1'b0;
            unload_en  <= 1'b0;
            rw         <= 1'b0;
            addr       <= '0;
            beat_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|w_req) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // Requests may have been withdrawn since IDLE saw them.
                    if (pick_any) begin
                        grant      <= pick_gnt;
                        own_idx    <= pick_idx;
                        addr       <= '0;
                        beat_valid <= 1'b1;
                        if (phase[pick_idx] == PHASE_ADD) begin
                            burst     <= BURST_W'(ADD_BURST);
                            add_en    <= 1'b1;
                            unload_en <= 1'b0;
                            rw        <= 1'b0;
                        end else begin
                            burst     <= BURST_W'(UNLOAD_BURST);
                            add_en    <= 1'b0;
                            unload_en <= 1'b1;
                            rw        <= 1'b1;
                        end
                        state <= ST_XFER;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    // The owner's request level is ignored here: a started
                    // burst always runs to completion.
                    if (w_bus_ack) begin
                        if (addr == burst - ONE) begin
                            grant      <= '0;
                            burst      <= '0;
                            add_en     <= 1'b0;
                            unload_en  <= 1'b0;
                            rw         <= 1'b0;
                            addr       <= '0;
                            beat_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            addr <= addr + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Phase flips only on completion, so an aborted burst
                    // leaves the core's next burst type unchanged.
                    done           <= 1'b0;
                    phase[own_idx] <= ~phase[own_idx];
                    ptr            <= own_idx;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_bus_scheduler.sv
// tb/tb_out_bus_scheduler.sv - self-checking bench for out_bus_scheduler
module tb_out_bus_scheduler;

    localparam int NC = 4;
    localparam int BW = 6;
    localparam int AB = 16;
    localparam int UB = 16;

    logic          w_clock;
    logic          w_ready;
    logic [NC-1:0] w_req;
    logic          w_bus_ack;
    logic [NC-1:0] grant;
    logic [BW-1:0] burst;
    logic          add_en;
    logic          unload_en;
    logic          rw;
    logic [BW-1:0] addr;
    logic          beat_valid;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference model: which core was served last and each core's next burst type.
    int m_ptr;
    bit m_phase [NC];

    out_bus_scheduler #(
        .NUM_CORES    (NC),
        .BURST_W      (BW),
        .ADD_BURST    (AB),
        .UNLOAD_BURST (UB)
    ) dut (
        .w_clock    (w_clock),
        .w_ready    (w_ready),
        .w_req      (w_req),
        .w_bus_ack  (w_bus_ack),
        .grant      (grant),
        .burst      (burst),
        .add_en     (add_en),
        .unload_en  (unload_en),
        .rw         (rw),
        .addr       (addr),
        .beat_valid (beat_valid),
        .done       (done)
    );

    initial w_clock = 1'b0;
    always #5 w_clock = ~w_clock;

    task automatic tick();
        @(posedge w_clock);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = NC - 1;
        for (int i = 0; i < NC; i++) m_phase[i] = 1'b0;
    endtask

    function automatic int model_pick(input logic [NC-1:0] req);
        for (int i = 1; i <= NC; i++) begin
            if (req[(m_ptr + i) % NC]) return (m_ptr + i) % NC;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        w_ready   = 1'b0;
        w_req     = '0;
        w_bus_ack = 1'b0;
        tick();
        tick();
        w_ready = 1'b1;
        model_reset();
    endtask

    // Runs one burst for req, checking owner, type, beat sequence and done.
    task automatic expect_burst(input logic [NC-1:0] req, input int stall_pct,
                                input int drop_at, output int lat);
        int c, e, xfer, stalls, guard;
        logic [NC-1:0] eg;
        int eb;
        bit ack;
        w_req = req;
        c = model_pick(req);
        eg = '0;
        eg[c] = 1'b1;
        eb = m_phase[c] ? UB : AB;
        lat = 0;
        while (!beat_valid && lat < 8) begin
            tick();
            lat++;
        end
        checks++;
        if (!beat_valid) begin
            errors++;
            $display("FAIL grant_timeout: no beat within %0d cycles", lat);
            return;
        end
        checks++;
        if (grant !== eg || burst !== BW'(eb) || add_en !== !m_phase[c] ||
            unload_en !== m_phase[c] || rw !== m_phase[c]) begin
            errors++;
            $display("FAIL burst_start: grant=%b burst=%0d add=%b unl=%b rw=%b need grant=%b burst=%0d phase=%0d",
                     grant, burst, add_en, unload_en, rw, eg, eb, m_phase[c]);
        end
        e = 0; xfer = 0; stalls = 0; guard = 0;
        while (beat_valid && guard < 400) begin
            checks++;
            if (addr !== BW'(e) || grant !== eg || done !== 1'b0) begin
                errors++;
                $display("FAIL beat: addr=%0d grant=%b done=%b need addr=%0d grant=%b",
                         addr, grant, done, e, eg);
            end
            if (e == drop_at) w_req = req & ~eg;
            ack = ($urandom_range(99) >= stall_pct);
            w_bus_ack = ack;
            tick();
            xfer++;
            guard++;
            if (ack) e++;
            else stalls++;
        end
        w_bus_ack = 1'b0;
        checks++;
        if (e !== eb || xfer !== eb + stalls) begin
            errors++;
            $display("FAIL beat_count: accepted=%0d xfer=%0d need accepted=%0d xfer=%0d",
                     e, xfer, eb, eb + stalls);
        end
        checks++;
        if (done !== 1'b1 || grant !== '0 || burst !== '0 || addr !== '0 ||
            add_en !== 1'b0 || unload_en !== 1'b0 || rw !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done=%b grant=%b burst=%0d addr=%0d need done=1 rest 0",
                     done, grant, burst, addr);
        end
        m_phase[c] = ~m_phase[c];
        m_ptr = c;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (grant !== '0 || burst !== '0 || add_en !== 1'b0 || unload_en !== 1'b0 ||
            rw !== 1'b0 || addr !== '0 || beat_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b burst=%0d addr=%0d bv=%b done=%b need all 0",
                     grant, burst, addr, beat_valid, done);
        end
    endtask

    task automatic test_basic();
        int lat;
        apply_reset();
        expect_burst(4'b0001, 0, -1, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL first_latency: got=%0d need=2", lat);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b need=0", done);
        end
        expect_burst(4'b0001, 0, -1, lat);
    endtask

    task automatic test_round_robin();
        int lat;
        apply_reset();
        for (int k = 0; k < 2 * NC; k++) begin
            expect_burst(4'b1111, 0, -1, lat);
            if (k > 0) begin
                checks++;
                if (lat !== 3) begin
                    errors++;
                    $display("FAIL turnaround: got=%0d need=3", lat);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        apply_reset();
        expect_burst(4'b0100, 0, -1, lat);
        expect_burst(4'b0011, 0, -1, lat);
        checks++;
        if (m_ptr !== 0) begin
            errors++;
            $display("FAIL wrap_model: got=%0d need=0", m_ptr);
        end
    endtask

    task automatic test_stall();
        int lat;
        for (int k = 0; k < 4; k++) expect_burst(4'(1 << k), 50, -1, lat);
    endtask

    task automatic test_drop();
        int lat;
        expect_burst(4'b0010, 20, 3, lat);
        expect_burst(4'b0010, 0, -1, lat);
    endtask

    task automatic test_withdraw();
        w_req = '0;
        tick();
        tick();
        w_req = 4'b0010;
        tick();
        w_req = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (grant !== '0 || beat_valid !== 1'b0) begin
                errors++;
                $display("FAIL withdraw: grant=%b bv=%b need 0", grant, beat_valid);
            end
        end
    endtask

    task automatic test_reset_midburst();
        int lat, guard;
        apply_reset();
        w_req = 4'b0100;
        guard = 0;
        while (!(beat_valid && addr == BW'(7)) && guard < 40) begin
            w_bus_ack = beat_valid;
            tick();
            guard++;
        end
        w_bus_ack = 1'b0;
        checks++;
        if (!(beat_valid && addr == BW'(7))) begin
            errors++;
            $display("FAIL midburst_reach: addr=%0d bv=%b need addr=7 bv=1", addr, beat_valid);
        end
        w_ready = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || burst !== '0 || add_en !== 1'b0 || unload_en !== 1'b0 ||
            rw !== 1'b0 || addr !== '0 || beat_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: grant=%b burst=%0d addr=%0d bv=%b need all 0",
                     grant, burst, addr, beat_valid);
        end
        tick();
        w_ready = 1'b1;
        model_reset();
        expect_burst(4'b0100, 0, -1, lat);
    endtask

    task automatic test_random();
        int lat, drop;
        logic [NC-1:0] req;
        for (int k = 0; k < 20; k++) begin
            req = NC'($urandom_range(1, 15));
            drop = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1;
            expect_burst(req, int'($urandom_range(60)), drop, lat);
        end
    endtask

    initial begin
        w_ready   = 1'b0;
        w_req     = '0;
        w_bus_ack = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_stall();
        test_drop();
        test_withdraw();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/out_bus_scheduler.md
# out_bus_scheduler

Round-robin scheduler for the shared output data bus between output-stationary PE cores and the output accumulator buffer. It arbitrates among core requests and alternates each core between an add burst (partial sums into the buffer) and an unload burst (results out). It sequences each burst beat by beat against a bus-ready handshake. It sits between the PE core array and the output buffer and is the only driver of the bus control signals.

## Interface
- NUM_CORES, `OUT_ARB_NUM_CORES` (4): number of requesting cores, 2..16
- BURST_W, 6: width of burst length and beat address
- ADD_BURST, 16: beats per add burst, 1..2^BURST_W-1
- UNLOAD_BURST, 16: beats per unload burst, 1..2^BURST_W-1
- w_clock  in  1  sole clock, rising edge
- w_ready  in  1  asynchronous active-low reset
- w_req  in  NUM_CORES  level request per core
- w_bus_ack  in  1  buffer accepts current beat this cycle
- grant  out  NUM_CORES  one-hot owner of bus, 0 when idle
- burst  out  BURST_W  length of current burst, 0 when idle
- add_en  out  1  current burst is an add burst
- unload_en  out  1  current burst is an unload burst
- rw  out  1  0 = core writes into buffer (add), 1 = buffer read out (unload)
- addr  out  BURST_W  beat index within burst
- beat_valid  out  1  a beat is presented this cycle
- done  out  1  one-cycle pulse after last beat accepted

## Operation
- States: IDLE, ARB, XFER, DONE (2-bit encoding from shared package).
- IDLE: if w_req != 0 -> ARB; else stay.
- ARB: pick first requesting core searching from ptr+1 upward, wrapping modulo NUM_CORES; load grant, burst, add_en/unload_en, rw from that core's phase bit; addr <= 0; -> XFER. If w_req == 0 in ARB (requests withdrawn) -> IDLE, no grant.
- Phase bit per core, reset 0. Phase 0: add burst, burst = ADD_BURST, add_en=1, rw=0. Phase 1: unload burst, burst = UNLOAD_BURST, unload_en=1, rw=1.
- XFER: beat_valid=1. Beat accepted when w_bus_ack=1: addr increments. When addr == burst-1 and w_bus_ack=1 -> DONE. w_bus_ack=0 holds addr and all outputs.
- DONE: done=1, grant/burst/add_en/unload_en/rw/addr/beat_valid = 0; toggle granted core's phase; ptr <= granted index; -> IDLE.
- Granted core dropping w_req mid-burst is ignored; burst always completes. Requests from other cores during XFER wait for next ARB.
- All outputs are driven 0 when not in XFER (except done in DONE); no tri-state.

## Timing
- Async reset: state IDLE, ptr = NUM_CORES-1 (core 0 first priority), all phase bits 0, all outputs 0.
- Reset mid-burst aborts immediately; the phase of the interrupted core is not toggled.
- Registered outputs. w_req seen in IDLE at edge k -> ARB; grant valid after edge k+1; first beat presented same cycle.
- Burst of B beats with no stalls: XFER occupies B cycles; done after edge following last accept. Minimum turnaround per burst: B+3 cycles (IDLE, ARB, B×XFER, DONE).
- addr never exceeds burst-1; no wrap within a burst.

## Structure
- Shared package / `parameters.vh`: state encodings, OUT_ARB_NUM_CORES, default ADD_BURST/UNLOAD_BURST, phase encoding constants.
- Sub-module rr_priority_picker: combinational rotating priority encoder (req vector, ptr) -> one-hot grant + index + any-valid.

## Test plan
- Reset, w_req=4'b0001, w_bus_ack=1 -> grant 0001 two cycles later, add_en=1, rw=0, addr 0..15, done pulse; repeat -> unload_en=1, rw=1, burst=16.
- w_req=4'b1111 held -> grants in order 0001,0010,0100,1000,0001; second round all unload bursts.
- ptr at core 2, w_req=4'b0011 -> core 0 granted (wrap-around).
- w_bus_ack toggling 1,0,0,1 -> addr holds during stall; total XFER cycles = burst + stall count.
- Core 1 drops w_req at beat 3 -> burst completes to addr 15, done pulses, phase toggled.
- Assert w_ready=0 at beat 7 of core 2 -> all outputs 0 immediately; next grant to core 2 is again an add burst.
